// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv_pkg                                                  |
// | Purpose  : Shared constants and packing helper for the 5x5 / 3x3      |
// |            convolution engine (top_conv, conv_pe).                   |
// | Contents : DATA_W, IMG, K, OUT_SIDE, ACC_W, PROD_W and the packed     |
// |            bus widths; pack_ofs() gives the bit offset of element    |
// |            (r,c) in a row-major packed square of side 'side'.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package conv_pkg;

  localparam int DATA_W   = 2;
  localparam int IMG      = 5;
  localparam int K        = 3;
  localparam int OUT_SIDE = IMG - K + 1;
  // Worst case 9 * 3 * 3 = 81 fits in 7 bits, so the sum never wraps.
  localparam int ACC_W    = 7;
  localparam int PROD_W   = 2 * DATA_W;

  localparam int WIN_W    = K * K * DATA_W;
  localparam int IN_W     = IMG * IMG * DATA_W;
  localparam int OUT_W    = OUT_SIDE * OUT_SIDE * DATA_W;

  // Bit offset of element (r,c) in a row-major packed square of side 'side'.
  function automatic int pack_ofs(input int side, input int r, input int c);
    return DATA_W * (side * r + c);
  endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_pe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv_pe                                                   |
// | Purpose  : Combinational 3x3 dot product of unsigned pixels and      |
// |            weights.                                                  |
// | Ports    : pix [WIN_W-1:0]  in  - 9 packed pixels, row-major         |
// |            wgt [WIN_W-1:0]  in  - 9 packed weights, row-major        |
// |            sum [ACC_W-1:0]  out - full-precision sum of products     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module conv_pe
  import conv_pkg::*;
(
  input  logic [WIN_W-1:0] pix,
  input  logic [WIN_W-1:0] wgt,
  output logic [ACC_W-1:0] sum
);

  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_acc;

  always_comb begin
    w_acc  = '0;
    w_prod = '0;
    for (int k = 0; k < K * K; k++) begin
      // Zero-extend both operands so the product is computed at full width.
      w_prod = {{(PROD_W - DATA_W){1'b0}}, pix[k*DATA_W +: DATA_W]} *
               {{(PROD_W - DATA_W){1'b0}}, wgt[k*DATA_W +: DATA_W]};
      w_acc  = w_acc + {{(ACC_W - PROD_W){1'b0}}, w_prod};
    end
  end

  assign sum = w_acc;

endmodule : conv_pe
`default_nettype wire

// File: rtl/top_conv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : top_conv                                                  |
// | Purpose  : Fully parallel 2-D convolution (valid mode, stride 1) of  |
// |            a 5x5 image of 2-bit pixels with a 3x3 kernel of 2-bit    |
// |            weights; 3x3 map of 2-bit results, one clock of latency.  |
// | Ports    : clk            in  - rising-edge clock                    |
// |            rst_n          in  - asynchronous active-low reset        |
// |            in     [49:0]  in  - packed image, row-major              |
// |            filter [17:0]  in  - packed kernel, row-major             |
// |            out    [17:0]  out - packed registered result, row-major  |
// | Config   : CONV_SAT_EN defined   -> sums clamp to 3                  |
// |            CONV_SAT_EN undefined -> sums truncate to low 2 bits      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module top_conv
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic [WIN_W-1:0] filter,
  output logic [OUT_W-1:0] out
);

  logic [OUT_W-1:0] w_next;
  logic [OUT_W-1:0] r_out;

  generate
    for (genvar r = 0; r < OUT_SIDE; r++) begin : g_row
      for (genvar c = 0; c < OUT_SIDE; c++) begin : g_col
        logic [WIN_W-1:0] w_win;
        logic [ACC_W-1:0] w_sum;

        // Gather the 3x3 window anchored at (r,c); correlation form, so the
        // kernel is applied without flipping.
        for (genvar i = 0; i < K; i++) begin : g_ki
          for (genvar j = 0; j < K; j++) begin : g_kj
            assign w_win[pack_ofs(K, i, j) +: DATA_W] =
                   in[pack_ofs(IMG, r + i, c + j) +: DATA_W];
          end
        end

        conv_pe u_pe (
          .pix (w_win),
          .wgt (filter),
          .sum (w_sum)
        );

`ifdef CONV_SAT_EN
        // Any bit above the output width means the sum exceeds the maximum.
        assign w_next[pack_ofs(OUT_SIDE, r, c) +: DATA_W] =
               (|w_sum[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
        logic w_unused_hi;
        assign w_unused_hi = ^w_sum[ACC_W-1:DATA_W];
        assign w_next[pack_ofs(OUT_SIDE, r, c) +: DATA_W] = w_sum[DATA_W-1:0];
`endif
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_next;
    end
  end

  assign out = r_out;

endmodule : top_conv
`default_nettype wire

// File: tb/tb_top_conv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_top_conv                                               |
// | Purpose  : Scoreboard bench for top_conv. Stimulus pushes expected   |
// |            results; a monitor pops and compares one clock later.     |
// |            Honours CONV_SAT_EN in its reference model.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_top_conv;

  typedef struct {
    logic [17:0] val;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [49:0] in_v;
  logic [17:0] filter_v;
  logic [17:0] out_v;

  int img[5][5];
  int flt[3][3];

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  top_conv dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in_v),
    .filter (filter_v),
    .out    (out_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [17:0] act,
                       input logic [17:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: out=%h expected=%h", name, act, expv);
    end
  endtask

  // Reference: straight from the definition of a valid-mode correlation.
  function automatic logic [17:0] model();
    logic [17:0] m;
    int s, red;
    m = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += img[r+i][c+j] * flt[i][j];
`ifdef CONV_SAT_EN
        red = (s > 3) ? 3 : s;
`else
        red = s % 4;
`endif
        m[2*(3*r+c) +: 2] = 2'(red);
      end
    end
    return m;
  endfunction

  task automatic drive();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        in_v[2*(5*r+c) +: 2] = 2'(img[r][c]);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        filter_v[2*(3*i+j) +: 2] = 2'(flt[i][j]);
  endtask

  task automatic randomize_arrays();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        img[r][c] = int'($urandom_range(3));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        flt[i][j] = int'($urandom_range(3));
  endtask

  task automatic fill(input int iv, input int fv);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        img[r][c] = iv;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        flt[i][j] = fv;
  endtask

  // Called right after a falling edge: drive and record the expectation.
  task automatic issue(input string tag, input logic [17:0] expv);
    exp_t e;
    drive();
    e.val = expv;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT result is valid one rising edge after each issue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.tag, out_v, e.val);
      end
    end
  end

  initial begin
    int id_img[5][5];
    logic [17:0] c_all_one;
    int wait_cnt;

    id_img = '{'{1,1,0,1,1}, '{0,0,1,0,0}, '{1,1,1,1,1},
               '{0,1,0,0,0}, '{1,1,0,1,0}};
`ifdef CONV_SAT_EN
    c_all_one = 18'h3FFFF;
`else
    c_all_one = 18'h15555;
`endif

    // Reset held with arbitrary inputs toggling underneath.
    rst_n = 1'b0;
    randomize_arrays();
    drive();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("reset_hold", out_v, 18'h0);
      randomize_arrays();
      drive();
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Identity kernel: out(r,c) = in(r+1,c+1).
    @(negedge clk);
    img = id_img;
    fill_filter_zero();
    flt[1][1] = 1;
    issue("identity", 18'h01544);

    // Asynchronous reset between edges while out is nonzero.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", out_v, 18'h0);
    @(negedge clk);
    check("reset_hold2", out_v, 18'h0);
    rst_n = 1'b1;

    @(negedge clk);
    fill(1, 1);
    issue("all_ones", c_all_one);

    @(negedge clk);
    fill(3, 3);
    issue("max_inputs", c_all_one);

    @(negedge clk);
    img = id_img;
    fill_filter_zero();
    issue("zero_filter", 18'h0);

    @(negedge clk);
    fill(0, 3);
    issue("zero_image", 18'h0);

    // Only weight (0,0)=2: out(r,c) = 2*in(r,c), no clamping needed.
    @(negedge clk);
    img = id_img;
    fill_filter_zero();
    flt[0][0] = 2;
    issue("small_sum", model());

    // Back-to-back random vectors, one per cycle.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      randomize_arrays();
      issue($sformatf("stream_%0d", n), model());
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic fill_filter_zero();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        flt[i][j] = 0;
  endtask

  // Absolute guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: sim_time=%0t limit=100000", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_top_conv
`default_nettype wire

// File: doc/top_conv.md
Name: top_conv

Overview:
- Single-channel 2-D convolution engine: a 5x5 image of 2-bit unsigned pixels convolved with a 3x3 kernel of 2-bit unsigned weights.
- Valid mode, stride 1; produces a 3x3 feature map of 2-bit results.
- Fully parallel: 9 dot products computed combinationally each cycle; result registered.
- Sits as the compute leaf under the accelerator's feature-map buffers.

Parameters:
- DATA_W, 2, bit width of each pixel, weight and output element (unsigned).
- IMG, 5, image side length.
- K, 3, kernel side length; output side = IMG-K+1 = 3.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  IMG*IMG*DATA_W = 50  packed image; pixel (r,c) at bits [DATA_W*(IMG*r+c) +: DATA_W], row-major, r,c from 0.
- filter  input  K*K*DATA_W = 18  packed kernel; weight (i,j) at bits [DATA_W*(K*i+j) +: DATA_W], row-major.
- out  output  (IMG-K+1)^2*DATA_W = 18  packed result; element (r,c) at bits [DATA_W*(3*r+c) +: DATA_W], row-major.

Behaviour:
- Reset: rst_n low forces out to all zeros immediately, independent of clk. Out holds zero while rst_n is low.
- Reset mid-operation: any pending result is discarded. First valid out appears on the first rising edge after rst_n deasserts.
- Per element: sum(r,c) = sum over i,j in 0..2 of in(r+i,c+j) * filter(i,j). Correlation form, no kernel flip.
- Arithmetic: unsigned. Products are 4 bits; accumulator is at least 7 bits (max 9*3*3 = 81). No overflow inside the accumulator.
- Output reduction to DATA_W bits: see Optional Feature.
- Latency: exactly 1 clock. out on edge N reflects in/filter sampled at edge N. No handshake; new inputs are accepted every cycle, so throughput is 1 result set per cycle.
- Inputs are not registered separately. The combinational path ends at the out register.
- Boundary cases:
  - all-zero filter or image gives all-zero out;
  - maximum inputs (all 3s) give sum 81 per element.
- No X propagation: out is never undefined after reset.

Optional Feature:
- Macro CONV_SAT_EN.
- Defined: each sum is clamped to 2^DATA_W-1 = 3 (saturate); sums 0..2 pass unchanged.
- Undefined: each sum is truncated to its low DATA_W bits (modulo 4).
- Interface is identical in both builds.

Decomposition:
- Package conv_pkg holds:
  - DATA_W, IMG, K constants;
  - derived OUT_SIDE = IMG-K+1;
  - ACC_W = 7;
  - a function for the packed-index offset DATA_W*(side*r+c).
- One sub-module, conv_pe: 3x3 dot-product unit.
  - Inputs: 9 pixels and 9 weights.
  - Output: one ACC_W sum, combinational.
  - top_conv instantiates it 9 times via generate, then applies saturate/truncate and the output register.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> out=0. Assert rst_n asynchronously mid-cycle while out is nonzero -> out=0 without a clock edge.
- Identity kernel:
  - filter = centre weight (1,1)=1, all others 0.
  - Image rows 11011 / 00100 / 11111 / 01000 / 11010.
  - After 1 clock: out elements (row-major) = 0,1,0 / 1,1,1 / 1,0,0.
- All-ones: image all 1, filter all 1 -> sum 9 per element.
  - CONV_SAT_EN: every element 3 (out=18'h3FFFF).
  - Without: every element 1.
- Maximum: image all 3, filter all 3 -> sum 81.
  - CONV_SAT_EN: all elements 3.
  - Without: all elements 1 (81 mod 4).
- Zero kernel / small sum:
  - filter all 0 -> out 0.
  - filter with only (0,0)=2 on the identity-kernel image -> out element (r,c) = 2*in(r,c) clamped: e.g. out(0,0)=2; out(0,2)=0.
- Streaming: change in/filter every cycle for 20 random vectors -> each out matches the golden model of the previous cycle's inputs, confirming 1-cycle latency with no bubbles.
